// File: rtl/uart_echo_checker.sv
// Initiator side of a UART echo link: sends an incrementing byte pattern, checks each echo
// against sent+ECHO_OFFSET and counts pass/fail/timeout. Optional stop-on-failure: ECHO_HALT_ON_FAIL_EN.
module uart_echo_checker #(
  parameter int unsigned CLOCK_RATE     = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = CLOCK_RATE / 1000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter logic [7:0]  SEED           = 8'h00,
  parameter logic [7:0]  ECHO_OFFSET    = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic        rx_ready,
  input  logic        rx_error,
  input  logic [7:0]  rx_data,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [15:0] timeout_count,
  output logic [7:0]  last_rx,
  output logic        busy,
  output logic        halted
);

  // Valid/ready: tx_start is a level request held until tx_done is seen high on a posedge;
  // rx_ready is a level that stays high until the line restarts, so it is consumed once
  // in WAIT_RX and must fall before the next transaction can be counted.

  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD     = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RX,
    S_RELEASE,
    S_GAP
`ifdef ECHO_HALT_ON_FAIL_EN
    ,
    S_HALT_REL,
    S_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] fail_q, fail_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  last_rx_q, last_rx_d;
  logic [7:0]  expect_rx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign expect_rx = byte_q + ECHO_OFFSET;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      byte_q    <= SEED;
      timer_q   <= 32'd0;
      pass_q    <= 16'd0;
      fail_q    <= 16'd0;
      tmo_q     <= 16'd0;
      last_rx_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      timer_q   <= timer_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      last_rx_q <= last_rx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    timer_d   = timer_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    last_rx_d = last_rx_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_done) begin
          state_d = S_WAIT_RX;
          timer_d = TIMEOUT_LOAD;
        end
      end
      S_WAIT_RX: begin
        // Error outranks data, and any rx outcome outranks a coincident timer expiry.
        if (rx_error) begin
          fail_d = sat_inc(fail_q);
`ifdef ECHO_HALT_ON_FAIL_EN
          state_d = S_HALT_REL;
`else
          state_d = S_RELEASE;
`endif
        end else if (rx_ready) begin
          last_rx_d = rx_data;
          if (rx_data == expect_rx) begin
            pass_d  = sat_inc(pass_q);
            state_d = S_RELEASE;
          end else begin
            fail_d = sat_inc(fail_q);
`ifdef ECHO_HALT_ON_FAIL_EN
            state_d = S_HALT_REL;
`else
            state_d = S_RELEASE;
`endif
          end
        end else if (timer_q == 32'd0) begin
          tmo_d = sat_inc(tmo_q);
`ifdef ECHO_HALT_ON_FAIL_EN
          state_d = S_HALT;
`else
          state_d = S_GAP;
          timer_d = GAP_LOAD;
`endif
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_RELEASE: begin
        if (!rx_ready && !rx_error) begin
          state_d = S_GAP;
          timer_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (timer_q == 32'd0) begin
          byte_d  = byte_q + 8'd1;
          state_d = enable ? S_SEND : S_IDLE;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
`ifdef ECHO_HALT_ON_FAIL_EN
      S_HALT_REL: begin
        if (!rx_ready && !rx_error) state_d = S_HALT;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data       = byte_q;
  assign tx_start      = (state_q == S_SEND);
  assign busy          = (state_q != S_IDLE);
  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign timeout_count = tmo_q;
  assign last_rx       = last_rx_q;
`ifdef ECHO_HALT_ON_FAIL_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker: bench-side uart_tx/echo model, scoreboard of expected
// outcomes popped whenever a result counter moves, and a final summary line.
module tb_uart_echo_checker;

  localparam int          TMO  = 20;
  localparam int          GAP  = 4;
  localparam logic [7:0]  SEED = 8'hFE;

  localparam int M_PASS = 0;
  localparam int M_BAD  = 1;
  localparam int M_NONE = 2;
  localparam int M_ERR  = 3;

  localparam logic [1:0] K_PASS = 2'd0;
  localparam logic [1:0] K_FAIL = 2'd1;
  localparam logic [1:0] K_TMO  = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        tx_done = 1'b0;
  logic        rx_ready = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [15:0] pass_count, fail_count, timeout_count;
  logic [7:0]  last_rx;
  logic        busy, halted;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  exp_byte;
  logic [7:0]  last_rx_m;
  int          pass_m, fail_m, tmo_m;

  uart_echo_checker #(
    .CLOCK_RATE(100000000),
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(GAP),
    .SEED(SEED),
    .ECHO_OFFSET(8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_done(tx_done),
    .rx_ready(rx_ready),
    .rx_error(rx_error),
    .rx_data(rx_data),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .timeout_count(timeout_count),
    .last_rx(last_rx),
    .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_totals(input string tag);
    chk({tag, "_pass"}, {16'd0, pass_count}, pass_m);
    chk({tag, "_fail"}, {16'd0, fail_count}, fail_m);
    chk({tag, "_tmo"}, {16'd0, timeout_count}, tmo_m);
    chk({tag, "_halted"}, {31'd0, halted}, 0);
  endtask

  task automatic model_reset();
    exp_byte  = SEED;
    last_rx_m = 8'd0;
    pass_m    = 0;
    fail_m    = 0;
    tmo_m     = 0;
    exp_q.delete();
  endtask

  // One full transaction: wait for the request, act as uart_tx, then play the echo side.
  task automatic txn(input int mode, input int rx_delay, input int hold, input bit drop_en,
                     output int wait_cyc);
    int          cyc;
    bit          got;
    logic [7:0]  rxb;
    logic [1:0]  kind;
    logic [1:0]  kind_obs;
    logic [9:0]  exp_e;
    logic [15:0] p0, f0, t0;
    wait_cyc = 0;
    while (tx_start !== 1'b1 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("tx_start_seen", {31'd0, tx_start}, 1);
    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_byte});
    if (drop_en) enable = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    chk("tx_hold", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, exp_byte});
    p0 = pass_count;
    f0 = fail_count;
    t0 = timeout_count;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("tx_start_drop", {31'd0, tx_start}, 0);

    case (mode)
      M_PASS:  begin rxb = exp_byte + 8'h01; kind = K_PASS; end
      M_BAD:   begin rxb = exp_byte + 8'h5A; kind = K_FAIL; end
      M_ERR:   begin rxb = exp_byte + 8'h01; kind = K_FAIL; end
      default: begin rxb = 8'h00;            kind = K_TMO;  end
    endcase
    // rx_error results leave last_rx untouched; data results capture the returned byte.
    exp_q.push_back({kind, (mode == M_PASS || mode == M_BAD) ? rxb : last_rx_m});

    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      if (mode != M_NONE && cyc == rx_delay) begin
        rx_data  = rxb;
        rx_ready = 1'b1;
        rx_error = (mode == M_ERR);
      end
      @(negedge clk);
      cyc++;
      rx_error = 1'b0;
      got = ({pass_count, fail_count, timeout_count} != {p0, f0, t0});
    end
    chk("result_seen", {31'd0, got}, 1);
    chk("latency", cyc, (mode == M_NONE) ? TMO : rx_delay + 1);

    kind_obs = (pass_count != p0) ? K_PASS : (fail_count != f0) ? K_FAIL : K_TMO;
    exp_e = exp_q.pop_front();
    chk("kind", {30'd0, kind_obs}, {30'd0, exp_e[9:8]});
    chk("last_rx", {24'd0, last_rx}, {24'd0, exp_e[7:0]});
    if (exp_e[9:8] == K_PASS) pass_m++;
    else if (exp_e[9:8] == K_FAIL) fail_m++;
    else tmo_m++;
    last_rx_m = exp_e[7:0];

    repeat (hold) @(negedge clk);
    if (hold > 0) chk("release_busy", {31'd0, busy}, 1);
    rx_ready = 1'b0;
    chk_totals("after_txn");
    exp_byte = exp_byte + 8'd1;
  endtask

  initial begin
    int w;
    int n;
    model_reset();

    // Reset values.
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, {24'd0, SEED});
    chk("rst_last_rx", {24'd0, last_rx}, 0);
    chk_totals("rst");
    rst = 1'b0;

    // Stray rx activity while idle is ignored.
    rx_data  = 8'hFF;
    rx_ready = 1'b1;
    rx_error = 1'b1;
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    rx_error = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk_totals("idle_stray");

    // Wrap-around run: FE, FF, 00 all echoed +1.
    enable = 1'b1;
    txn(M_PASS, $urandom_range(0, 5), $urandom_range(1, 3), 1'b0, w);
    txn(M_PASS, $urandom_range(0, 5), $urandom_range(1, 3), 1'b0, w);
    txn(M_PASS, $urandom_range(0, 5), 0, 1'b0, w);
    // Minimum latency, then the RELEASE->GAP path costs GAP+1 cycles to the next request.
    txn(M_PASS, 0, 0, 1'b0, w);
    chk("gap_after_release", w, GAP + 1);
    txn(M_PASS, 0, 2, 1'b0, w);

    // Wrong byte is a failure; the pattern keeps incrementing.
    txn(M_BAD, $urandom_range(0, 5), 1, 1'b0, w);
    txn(M_PASS, $urandom_range(0, 5), 1, 1'b0, w);

    // No echo: timeout exactly TMO cycles after tx_done, straight into GAP.
    txn(M_NONE, 0, 0, 1'b0, w);
    txn(M_PASS, 2, 1, 1'b0, w);
    chk("gap_after_timeout", w, GAP);

    // rx_error with a correct byte counts as a fail; a 50-cycle ready counts once.
    txn(M_ERR, 1, 50, 1'b0, w);
    txn(M_PASS, 0, 50, 1'b0, w);

    // enable dropped during SEND: transaction still counted, then parks in IDLE.
    txn(M_PASS, 1, 1, 1'b1, w);
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("park_idle_busy", {31'd0, busy}, 0);
    rx_data  = 8'h00;
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    rx_ready = 1'b0;
    chk("park_no_start", {31'd0, tx_start}, 0);
    chk_totals("park");
    enable = 1'b1;
    txn(M_PASS, 3, 1, 1'b0, w);

    // Reset while tx_start is high.
    n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_tx_start", {31'd0, tx_start}, 1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_send_tx_start", {31'd0, tx_start}, 0);
    chk("arst_send_busy", {31'd0, busy}, 0);
    chk("arst_send_tx_data", {24'd0, tx_data}, {24'd0, SEED});
    chk_totals("arst_send");
    @(negedge clk);
    rst = 1'b0;

    // Reset while waiting for the echo, with a correct echo already on the line.
    n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
    chk("pre_rst_wait_busy", {31'd0, busy}, 1);
    rx_data  = SEED + 8'h01;
    rx_ready = 1'b1;
    enable   = 1'b0;
    rst      = 1'b1;
    #1;
    chk("arst_wait_busy", {31'd0, busy}, 0);
    chk("arst_wait_last_rx", {24'd0, last_rx}, 0);
    chk_totals("arst_wait");
    @(negedge clk);
    rx_ready = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk_totals("post_rst");

    // Fresh start after reset resumes from SEED.
    enable = 1'b1;
    txn(M_PASS, $urandom_range(0, 5), 1, 1'b0, w);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
